seg_pipe_adder: RTL

- Parametrised, pipelined, segmented ripple-carry adder. Successor to the single-bit full adder.
- Adds two WIDTH-bit operands plus carry-in. Processes one SEG_W-bit segment per pipeline stage, so the carry chain is cut into NSEG = WIDTH/SEG_W registered stages.
- Sits in arithmetic datapaths that need full-rate throughput at high clock frequency. Uses valid/ready handshakes on both sides.

---
 rtl/seg_pipe_adder_pkg.sv | 15 +
 rtl/seg_pipe_adder_if.sv | 41 ++++
 rtl/seg_pipe_adder_add_stage.sv | 33 +++
 rtl/seg_pipe_adder.sv | 123 ++++++++++++
 4 files changed

// File: rtl/seg_pipe_adder_pkg.sv
// Shared widths and elaboration helpers for the segmented pipelined adder.
package seg_pipe_adder_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_SEG_W = 8;

  function automatic int nseg(input int width, input int seg_w);
    return (seg_w > 0) ? (width / seg_w) : 0;
  endfunction

  function automatic bit params_ok(input int width, input int seg_w);
    return (seg_w >= 1) && (width >= seg_w) && ((width % seg_w) == 0);
  endfunction

endpackage

// File: rtl/seg_pipe_adder_if.sv
// Operand/result handshake bundle; ovf exists only with SEG_PIPE_ADDER_OVF_EN.
interface seg_pipe_adder_if
  import seg_pipe_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef SEG_PIPE_ADDER_OVF_EN
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
`else
  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout
  );
`endif

endinterface

// File: rtl/seg_pipe_adder_add_stage.sv
// One registered SEG_W-bit ripple segment: sum, carry and valid advance on en.
module seg_add_stage #(
  parameter int SEG_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             vld_in,
  input  logic             cin,
  input  logic [SEG_W-1:0] a_seg,
  input  logic [SEG_W-1:0] b_seg,
  output logic [SEG_W-1:0] sum_seg,
  output logic             cout,
  output logic             vld
);

  logic [SEG_W:0] add_w;

  assign add_w = {1'b0, a_seg} + {1'b0, b_seg} + {{SEG_W{1'b0}}, cin};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld     <= 1'b0;
      cout    <= 1'b0;
      sum_seg <= '0;
    end else if (en) begin
      vld     <= vld_in;
      cout    <= add_w[SEG_W];
      sum_seg <= add_w[SEG_W-1:0];
    end
  end

endmodule

// File: rtl/seg_pipe_adder.sv
// Pipelined segmented adder: one SEG_W slice per stage, operands skewed in, sums deskewed out.
// Optional signed-overflow output is enabled by defining SEG_PIPE_ADDER_OVF_EN.
module seg_pipe_adder
  import seg_pipe_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SEG_W = DEF_SEG_W
) (
  input  logic            clk,
  input  logic            rst,
  seg_pipe_adder_if.slave bus
);

  localparam int NSEG = nseg(WIDTH, SEG_W);

  if (!params_ok(WIDTH, SEG_W)) begin : g_bad_params
    $error("seg_pipe_adder: WIDTH=%0d must be a nonzero multiple of SEG_W=%0d", WIDTH, SEG_W);
  end

  logic             stall;
  logic             en;
  logic [NSEG:0]    cy_c;
  logic [NSEG:0]    vld_c;
  logic [SEG_W-1:0] a_stg [NSEG];
  logic [SEG_W-1:0] b_stg [NSEG];
  logic [SEG_W-1:0] s_stg [NSEG];
  logic [SEG_W-1:0] s_out [NSEG];

  // The whole pipe freezes as one, bubbles included, while the result is refused.
  assign stall        = bus.out_valid & ~bus.out_ready;
  assign en           = ~stall;
  assign bus.in_ready = en;

  assign cy_c[0]       = bus.cin;
  assign vld_c[0]      = bus.in_valid;
  assign bus.out_valid = vld_c[NSEG];
  assign bus.cout      = cy_c[NSEG];

  for (genvar k = 0; k < NSEG; k++) begin : g_seg

    // Segment k is delayed k cycles so it meets the carry rippling out of stage k-1.
    if (k == 0) begin : g_direct
      assign a_stg[k] = bus.a[k*SEG_W +: SEG_W];
      assign b_stg[k] = bus.b[k*SEG_W +: SEG_W];
    end else begin : g_skew
      logic [SEG_W-1:0] a_dly_p [k];
      logic [SEG_W-1:0] b_dly_p [k];

      always_ff @(posedge clk) begin
        if (en) begin
          a_dly_p[0] <= bus.a[k*SEG_W +: SEG_W];
          b_dly_p[0] <= bus.b[k*SEG_W +: SEG_W];
          for (int d = 1; d < k; d++) begin
            a_dly_p[d] <= a_dly_p[d-1];
            b_dly_p[d] <= b_dly_p[d-1];
          end
        end
      end

      assign a_stg[k] = a_dly_p[k-1];
      assign b_stg[k] = b_dly_p[k-1];
    end

    seg_add_stage #(
      .SEG_W (SEG_W)
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .vld_in  (vld_c[k]),
      .cin     (cy_c[k]),
      .a_seg   (a_stg[k]),
      .b_seg   (b_stg[k]),
      .sum_seg (s_stg[k]),
      .cout    (cy_c[k+1]),
      .vld     (vld_c[k+1])
    );

    // Lower segments finish early and wait NSEG-1-k cycles to line up with the top one.
    if (k == NSEG - 1) begin : g_last
      assign s_out[k] = s_stg[k];
    end else begin : g_deskew
      localparam int L = NSEG - 1 - k;
      logic [SEG_W-1:0] s_dly_p [L];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int d = 0; d < L; d++) begin
            s_dly_p[d] <= '0;
          end
        end else if (en) begin
          s_dly_p[0] <= s_stg[k];
          for (int d = 1; d < L; d++) begin
            s_dly_p[d] <= s_dly_p[d-1];
          end
        end
      end

      assign s_out[k] = s_dly_p[L-1];
    end

    assign bus.sum[k*SEG_W +: SEG_W] = s_out[k];
  end

`ifdef SEG_PIPE_ADDER_OVF_EN
  logic sa_p;
  logic sb_p;

  // Operand sign bits captured alongside the top stage; a^b^s at the MSB is the carry into it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sa_p <= 1'b0;
      sb_p <= 1'b0;
    end else if (en) begin
      sa_p <= a_stg[NSEG-1][SEG_W-1];
      sb_p <= b_stg[NSEG-1][SEG_W-1];
    end
  end

  assign bus.ovf = sa_p ^ sb_p ^ bus.sum[WIDTH-1] ^ bus.cout;
`endif

endmodule
